// File: rtl/uart_line_rx.sv
// uart_line_rx: 16x-oversampled UART receiver with a small receive FIFO.
// Define UART_LINE_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_line_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       baudtick,
  input  logic       rxd,
  input  logic       enable,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun,
  output logic [3:0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_LINE_RX_MAJORITY_EN
  localparam logic [3:0] START_CNT = 4'd8;
`else
  localparam logic [3:0] START_CNT = 4'd7;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic rxd_m, rxd_s, rxd_p;
  logic [1:0] arm;
  logic [3:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic fall, at_sample, smp, push_req, ferr_req, pop, full, do_push, ovr_req;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  // rxd_p only loads once rxd_s carries the real line, so the synchronizer
  // reset value never fakes a start edge after reset release.
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b0;
      arm   <= 2'b00;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= arm[1] & rxd_s;
      arm   <= {arm[0], 1'b1};
    end
  assign fall = enable & rxd_p & ~rxd_s;
`ifdef UART_LINE_RX_MAJORITY_EN
  logic [1:0] hist;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) hist <= 2'b11;
    else if (baudtick) hist <= {hist[0], rxd_s};
  assign smp = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
  assign smp = rxd_s;
`endif
  assign at_sample = baudtick && cnt == (state == START ? START_CNT : 4'd15);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else
      unique case (state)
        IDLE:  if (fall) state_nx = START;
        START: if (at_sample) state_nx = smp ? IDLE : DATA;
        DATA:  if (at_sample && bit_idx == 3'd7) state_nx = STOP;
        STOP:  if (at_sample) state_nx = IDLE;
      endcase
  end
  always_comb begin
    rx_busy  = state != IDLE;
    push_req = enable && state == STOP && at_sample && smp;
    ferr_req = enable && state == STOP && at_sample && !smp;
  end
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (state == IDLE || !enable) begin
      cnt     <= '0;
      bit_idx <= '0;
    end else if (baudtick) begin
      cnt <= (state == START && at_sample) ? 4'd0 : cnt + 4'd1;
      if (state == DATA && at_sample) begin
        shreg   <= {smp, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  assign pop     = rx_valid & rx_ready;
  assign full    = fifo_level == 4'(FIFO_DEPTH);
  assign do_push = push_req & (~full | pop);
  assign ovr_req = push_req & full & ~pop;
  always_ff @(posedge PCLK)
    if (do_push) mem[wr] <= shreg;
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      rd         <= '0;
      wr         <= '0;
      fifo_level <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      fifo_level <= fifo_level + {3'b0, do_push} - {3'b0, pop};
      frame_err  <= ferr_req;
      overrun    <= ovr_req;
    end
  assign rx_valid = fifo_level != 4'd0;
  assign rx_data  = rx_valid ? mem[rd] : 8'h00;
endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: directed checks of uart_line_rx with a 4-PCLK baudtick.
module tb_uart_line_rx;
  logic PCLK = 0, PRESETn = 0, baudtick = 0, rxd = 1, enable = 1, rx_ready = 1;
  logic [7:0] rx_data;
  logic rx_valid, rx_busy, frame_err, overrun;
  logic [3:0] fifo_level;
  int total = 0, bad = 0, vcnt = 0, fe_cnt = 0, ov_cnt = 0, div = 0;
  logic [7:0] last = 0;
  logic [7:0] exp_q [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] frm;
  logic [7:0] glitch_exp;

  uart_line_rx #(.FIFO_DEPTH(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .baudtick(baudtick), .rxd(rxd), .enable(enable),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun(overrun), .fifo_level(fifo_level)
  );

  always #5 PCLK = ~PCLK;

  always @(negedge PCLK) begin
    div = (div + 1) % 4;
    baudtick = (div == 0);
    if (rx_valid) begin vcnt++; last = rx_data; end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge PCLK); while (!baudtick);
  endtask

  task automatic send_bit(input logic v, input int g);
    for (int k = 0; k < 16; k++) begin
      #1 rxd = (k == g) ? ~v : v;
      wait_tick();
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int g);
    wait_tick();
    send_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) send_bit(d[i], i == 0 ? g : -1);
    send_bit(stop, -1);
    send_bit(1'b1, -1);
    send_bit(1'b1, -1);
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    PRESETn = 1;
    repeat (8) wait_tick();

    vcnt = 0; fe_cnt = 0;
    send_frame(8'hA5, 1'b1, -1);
    @(negedge PCLK);
    chk("a5_valid_cycles", vcnt, 1);
    chk("a5_data", last, 8'hA5);
    chk("a5_ferr", fe_cnt, 0);
    chk("a5_level", fifo_level, 0);

    vcnt = 0;
    wait_tick();
    #1 rxd = 0;
    repeat (4) wait_tick();
    @(negedge PCLK);
    chk("false_busy_mid", rx_busy, 1);
    rxd = 1;
    repeat (12) wait_tick();
    @(negedge PCLK);
    chk("false_busy_end", rx_busy, 0);
    chk("false_level", fifo_level, 0);
    chk("false_valid_cycles", vcnt, 0);

    vcnt = 0; fe_cnt = 0;
    send_frame(8'h3C, 1'b0, -1);
    @(negedge PCLK);
    chk("ferr_pulses", fe_cnt, 1);
    chk("ferr_level", fifo_level, 0);
    chk("ferr_valid_cycles", vcnt, 0);

    rx_ready = 0; ov_cnt = 0;
    for (int i = 0; i < 4; i++) send_frame(exp_q[i], 1'b1, -1);
    @(negedge PCLK);
    chk("fill_level", fifo_level, 4);
    chk("fill_ovr", ov_cnt, 0);
    send_frame(8'h77, 1'b1, -1);
    @(negedge PCLK);
    chk("ovr_pulses", ov_cnt, 1);
    chk("ovr_level", fifo_level, 4);
    chk("ovr_head", rx_data, 8'h11);
    for (int i = 0; i < 4; i++) begin
      chk("pop_data", rx_data, exp_q[i]);
      rx_ready = 1;
      @(negedge PCLK);
      rx_ready = 0;
    end
    chk("pop_level", fifo_level, 0);
    chk("pop_valid", rx_valid, 0);
    rx_ready = 1;

    vcnt = 0;
    frm = 8'h5A;
    wait_tick();
    send_bit(1'b0, -1);
    for (int i = 0; i < 3; i++) send_bit(frm[i], -1);
    #1 rxd = frm[3];
    repeat (8) wait_tick();
    @(negedge PCLK);
    PRESETn = 0;
    @(negedge PCLK);
    chk("midrst_busy", rx_busy, 0);
    chk("midrst_level", fifo_level, 0);
    rxd = 1;
    repeat (3) @(negedge PCLK);
    PRESETn = 1;
    repeat (40) wait_tick();
    @(negedge PCLK);
    chk("midrst_idle", rx_busy, 0);
    send_frame(8'h5A, 1'b1, -1);
    @(negedge PCLK);
    chk("midrst_count", vcnt, 1);
    chk("midrst_data", last, 8'h5A);

`ifdef UART_LINE_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h01;
`endif
    vcnt = 0;
    send_frame(8'h00, 1'b1, 7);
    @(negedge PCLK);
    chk("glitch_count", vcnt, 1);
    chk("glitch_data", last, glitch_exp);

    vcnt = 0;
    wait_tick();
    send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    @(negedge PCLK);
    chk("en_busy_mid", rx_busy, 1);
    enable = 0;
    @(negedge PCLK);
    chk("en_busy_off", rx_busy, 0);
    wait_tick();
    for (int i = 0; i < 7; i++) send_bit(1'b0, -1);
    send_bit(1'b1, -1);
    send_bit(1'b1, -1);
    enable = 1;
    repeat (4) wait_tick();
    @(negedge PCLK);
    chk("en_valid_cycles", vcnt, 0);
    chk("en_level", fifo_level, 0);
    chk("en_busy_end", rx_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
